// File: rtl/float_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa
// product, round-to-nearest-even, fixed 28-cycle latency, valid/ready on both sides.
module float_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_MUL    = 3'd2,
    ST_NORM   = 3'd3,
    ST_ROUND  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE    = 2'd0,
    SP_INVALID = 2'd1,
    SP_INF     = 2'd2,
    SP_ZERO    = 2'd3
  } special_t;

  localparam logic [1:0] CL_ZERO   = 2'd0;
  localparam logic [1:0] CL_INF    = 2'd1;
  localparam logic [1:0] CL_NAN    = 2'd2;
  localparam logic [1:0] CL_NORMAL = 2'd3;

  // Exponent field 0 covers true zeros and denormals, which are flushed.
  function automatic logic [1:0] classify(input logic [31:0] x);
    logic [1:0] cls;
    case (x[30:23])
      8'h00:   cls = CL_ZERO;
      8'hFF:   cls = (x[22:0] == 23'd0) ? CL_INF : CL_NAN;
      default: cls = CL_NORMAL;
    endcase
    return cls;
  endfunction

  state_t            state_r, state_next_s;
  special_t          special_r, special_s;
  logic [31:0]       a_r, b_r;
  logic              sign_r;
  logic [7:0]        exp_a_r, exp_b_r;
  logic [23:0]       mcand_r, mplier_r;
  logic [4:0]        cnt_r;
  logic [47:0]       acc_r;
  logic signed [9:0] exp_r;
  logic signed [9:0] exp_sum_s;
  logic [22:0]       mant_r;
  logic              guard_r, sticky_r;
  logic [1:0]        cls_a_s, cls_b_s;
  logic              round_up_s;
  logic [23:0]       mant_sum_s;
  logic [22:0]       mant_fin_s;
  logic signed [9:0] exp_fin_s;
  logic [31:0]       res_s;
  logic [2:0]        flg_s;
  logic [31:0]       result_r;
  logic [2:0]        flags_r;
  logic              out_valid_r, in_ready_r;

  assign cls_a_s   = classify(a_r);
  assign cls_b_s   = classify(b_r);
  assign exp_sum_s = $signed({2'b00, exp_a_r}) + $signed({2'b00, exp_b_r}) - 10'sd127;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flags     = flags_r;

  // Special-case code, in exception priority order.
  always_comb begin
    special_s = SP_NONE;
    if ((cls_a_s == CL_NAN) || (cls_b_s == CL_NAN) ||
        ((cls_a_s == CL_INF) && (cls_b_s == CL_ZERO)) ||
        ((cls_a_s == CL_ZERO) && (cls_b_s == CL_INF))) begin
      special_s = SP_INVALID;
    end else if ((cls_a_s == CL_INF) || (cls_b_s == CL_INF)) begin
      special_s = SP_INF;
    end else if ((cls_a_s == CL_ZERO) || (cls_b_s == CL_ZERO)) begin
      special_s = SP_ZERO;
    end else begin
      special_s = SP_NONE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_UNPACK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_UNPACK: state_next_s = ST_MUL;
      ST_MUL: begin
        if (cnt_r == 5'd23) begin
          state_next_s = ST_NORM;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_NORM:  state_next_s = ST_ROUND;
      ST_ROUND: state_next_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Rounding and final exception selection, evaluated while in ROUND.
  always_comb begin
    round_up_s = guard_r & (sticky_r | mant_r[0]);
    mant_sum_s = {1'b0, mant_r} + {23'd0, round_up_s};
    mant_fin_s = mant_sum_s[22:0];
    exp_fin_s  = exp_r;
    res_s      = 32'd0;
    flg_s      = 3'b000;
    if (mant_sum_s[23]) begin
      mant_fin_s = 23'd0;
      exp_fin_s  = exp_r + 10'sd1;
    end else begin
      mant_fin_s = mant_sum_s[22:0];
      exp_fin_s  = exp_r;
    end
    case (special_r)
      SP_INVALID: begin
        res_s = 32'h7FC0_0000;
        flg_s = 3'b100;
      end
      SP_INF:  res_s = {sign_r, 8'hFF, 23'd0};
      SP_ZERO: res_s = {sign_r, 31'd0};
      SP_NONE: begin
        if (exp_fin_s >= 10'sd255) begin
          res_s = {sign_r, 8'hFF, 23'd0};
          flg_s = 3'b010;
        end else if (exp_fin_s <= 10'sd0) begin
          res_s = {sign_r, 31'd0};
          flg_s = 3'b001;
        end else begin
          res_s = {sign_r, exp_fin_s[7:0], mant_fin_s};
          flg_s = 3'b000;
        end
      end
      default: begin
        res_s = 32'd0;
        flg_s = 3'b000;
      end
    endcase
  end

  // Operand capture, shift-add multiply and normalisation datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      sign_r    <= 1'b0;
      exp_a_r   <= 8'd0;
      exp_b_r   <= 8'd0;
      mcand_r   <= 24'd0;
      mplier_r  <= 24'd0;
      special_r <= SP_NONE;
      cnt_r     <= 5'd0;
      acc_r     <= 48'd0;
      exp_r     <= 10'sd0;
      mant_r    <= 23'd0;
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
          end
        end
        ST_UNPACK: begin
          sign_r    <= a_r[31] ^ b_r[31];
          exp_a_r   <= a_r[30:23];
          exp_b_r   <= b_r[30:23];
          mcand_r   <= {1'b1, a_r[22:0]};
          mplier_r  <= {1'b1, b_r[22:0]};
          special_r <= special_s;
          cnt_r     <= 5'd0;
          acc_r     <= 48'd0;
        end
        ST_MUL: begin
          if (mplier_r[cnt_r]) begin
            acc_r <= acc_r + ({24'd0, mcand_r} << cnt_r);
          end
          cnt_r <= cnt_r + 5'd1;
        end
        ST_NORM: begin
          // Product of two [1,2) mantissas lies in [1,4); bit 47 flags the upper half.
          if (acc_r[47]) begin
            mant_r   <= acc_r[46:24];
            guard_r  <= acc_r[23];
            sticky_r <= |acc_r[22:0];
            exp_r    <= exp_sum_s + 10'sd1;
          end else begin
            mant_r   <= acc_r[45:23];
            guard_r  <= acc_r[22];
            sticky_r <= |acc_r[21:0];
            exp_r    <= exp_sum_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered handshake flags and result; result/flags load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= 32'd0;
      flags_r     <= 3'b000;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      out_valid_r <= (state_next_s == ST_DONE);
      in_ready_r  <= (state_next_s == ST_IDLE);
      if (state_r == ST_ROUND) begin
        result_r <= res_s;
        flags_r  <= flg_s;
      end
    end
  end

endmodule

// File: tb/tb_float_mul_seq.sv
// Self-checking bench for float_mul_seq: directed vector table, handshake corner
// sequences, and random operands against an arithmetic reference model.
module tb_float_mul_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  float_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: exact integer product, RNE by remainder comparison, FTZ in and out.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    logic s;
    bit zx, zy, ix, iy, nx, ny;
    longint unsigned p, q, rem, half;
    logic [31:0] r;
    logic [2:0]  f;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 23'd0);
    iy = (ey == 255) && (y[22:0] == 23'd0);
    nx = (ex == 255) && (x[22:0] != 23'd0);
    ny = (ey == 255) && (y[22:0] != 23'd0);
    f  = 3'b000;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      r = 32'h7FC0_0000;
      f = 3'b100;
    end else if (ix || iy) begin
      r = {s, 8'hFF, 23'd0};
    end else if (zx || zy) begin
      r = {s, 31'd0};
    end else begin
      p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e  = ex + ey - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 3'b010;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 3'b001;
      end else begin
        r = {s, e[7:0], q[22:0]};
      end
    end
    return {f, r};
  endfunction

  // Called one step after the accept edge; returns cycle offset at which out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic transact(input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [31:0] er, input logic [2:0] ef, input string nm);
    int n;
    int lat;
    a = ta; b = tbv; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_busy"}, {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    check({nm, "_latency"}, lat, 32'd28);
    check({nm, "_result"}, result, er);
    check({nm, "_flags"}, {29'd0, flags}, {29'd0, ef});
    @(posedge clk); #1;
    check({nm, "_post_ready"}, {31'd0, in_ready}, 32'd1);
    check({nm, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    check({nm, "_post_hold"}, result, er);
  endtask

  vec_t vecs[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [34:0] expv;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h4040_0000, 32'h4020_0000, 32'h40F0_0000, 3'b000};
    vecs[1] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000};
    vecs[2] = '{32'h3F80_0000, 32'h8000_0000, 32'h8000_0000, 3'b000};
    vecs[3] = '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 3'b010};
    vecs[4] = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b001};
    vecs[5] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100};
    vecs[6] = '{32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000};
    vecs[7] = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3'b000};
    vecs[8] = '{32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 3'b100};
    vecs[9] = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_flags", {29'd0, flags}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      transact(vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].flg, $sformatf("vec%0d", i));
    end

    // Backpressure: result held, new operands refused until the output handshake.
    a = 32'h4040_0000; b = 32'h4020_0000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_latency", lat, 32'd28);
    a = 32'h4000_0000; b = 32'h4000_0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_result", result, 32'h40F0_0000);
      check("bp_hold_flags", {29'd0, flags}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_keep", result, 32'h40F0_0000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_busy", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    check("bp_second_latency", lat, 32'd28);
    check("bp_second_result", result, 32'h4080_0000);
    @(posedge clk); #1;

    // Reset in the middle of an operation discards it.
    a = 32'h4040_0000; b = 32'h4020_0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) lat++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_output", lat, 32'd0);
    transact(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 3'b000, "rst_after");

    // Random operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 19))
        0:       ra[30:23] = 8'h00;
        1:       begin ra[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) ra[22:0] = 23'd0; end
        2:       rb[30:23] = 8'h00;
        3:       begin rb[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) rb[22:0] = 23'd0; end
        default: begin
          ra[30:23] = 8'($urandom_range(64, 190));
          rb[30:23] = 8'($urandom_range(64, 190));
        end
      endcase
      expv = ref_mul(ra, rb);
      transact(ra, rb, expv[31:0], expv[34:32], $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
